mc_datapath_hs: RTL and testbench

Parametrised multicycle RISC-V datapath, successor to the fixed 32-bit multicycle datapath. It keeps the same controller-driven control-signal contract (PC/oldPC/IR/MDR/A/B/ALUOut registers plus A/B/result muxes). It generalises word width and register count, and adds four behaviours:
- an external memory bus with a req/ready handshake and a stall output;
- byte/half/word store strobes;
- sign/zero-extended sub-word loads;
- misalignment detection.

It sits between the multicycle controller and the system memory/bus adapter.

---
 rtl/mc_datapath_hs_if.sv | 23 ++
 rtl/mc_datapath_hs.sv | 198 +++++++++++++++++++
 tb/tb_mc_datapath_hs.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_hs_if.sv
// Memory bus between the multicycle datapath (master) and the system bus adapter (slave).
// A transfer completes on the first rising edge with mem_req and mem_ready both high.
interface mc_datapath_hs_if #(
  parameter int XLEN = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_datapath_hs.sv
// Parametrised multicycle RISC-V datapath with a handshaked memory bus, sub-word
// loads/stores with lane steering, and misalignment detection; stall freezes all state.
module mc_datapath_hs #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             IRWrite,
  input  logic             regWrite,
  input  logic             addrSrc,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [1:0]       resultSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [2:0]       ALUControl,
  input  logic [2:0]       immSrc,
  output logic [6:0]       opcode,
  output logic [2:0]       func3,
  output logic             func7,
  output logic             zero,
  output logic             neg,
  output logic             stall,
  output logic             misalign,
  mc_datapath_hs_if.master bus
);
  localparam int NB  = XLEN / 8;
  localparam int LB  = $clog2(NB);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d, mdr_q, mdr_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] rf_q [32];

  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_res, result, ea;
  logic [XLEN-1:0] rdata_sh, load_ext;
  logic [31:0]     imm32;
  logic [1:0]      sz;
  logic [2:0]      align_m;
  logic [7:0]      byte_m;
  logic [LB-1:0]   lane;
  logic            mem_access, req, we, rf_we;

  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];
  assign opcode = ir_q[6:0];
  assign func3  = ir_q[14:12];
  assign func7  = ir_q[30];

  // Indices at or above NREGS behave like x0.
  assign rd1 = (rs1 != 5'd0 && int'(rs1) < NREGS) ? rf_q[rs1] : '0;
  assign rd2 = (rs2 != 5'd0 && int'(rs2) < NREGS) ? rf_q[rs2] : '0;

  always_comb begin
    imm32 = '0;
    case (immSrc)
      3'd0:    imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      3'd1:    imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'd2:    imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'd3:    imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      3'd4:    imm32 = {ir_q[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm_ext = XLEN'($signed(imm32));

  always_comb begin
    src_a = '0;
    case (ALUSrcA)
      2'd0:    src_a = pc_q;
      2'd1:    src_a = old_pc_q;
      2'd2:    src_a = a_q;
      default: src_a = '0;
    endcase
    src_b = '0;
    case (ALUSrcB)
      2'd0:    src_b = b_q;
      2'd1:    src_b = imm_ext;
      2'd2:    src_b = XLEN'(4);
      default: src_b = '0;
    endcase
    alu_res = '0;
    case (ALUControl)
      3'd0:    alu_res = src_a + src_b;
      3'd1:    alu_res = src_a - src_b;
      3'd2:    alu_res = src_a & src_b;
      3'd3:    alu_res = src_a | src_b;
      3'd4:    alu_res = src_a ^ src_b;
      3'd5:    alu_res = XLEN'($signed(src_a) < $signed(src_b));
      3'd6:    alu_res = XLEN'(src_a < src_b);
      default: alu_res = src_a << src_b[SHW-1:0];
    endcase
    result = alu_out_q;
    case (resultSrc)
      2'd0:    result = alu_out_q;
      2'd1:    result = mdr_q;
      2'd2:    result = alu_res;
      default: result = imm_ext;
    endcase
  end

  assign zero = (alu_res == '0);
  assign neg  = alu_res[XLEN-1];

  // Instruction fetches are always 32-bit; data accesses take their size from func3.
  assign ea = addrSrc ? result : pc_q;
  always_comb begin
    sz = addrSrc ? ir_q[13:12] : 2'd2;
    if (NB == 4 && sz == 2'd3) sz = 2'd2;
    align_m = 3'b111;
    byte_m  = 8'hFF;
    case (sz)
      2'd0:    begin align_m = 3'b000; byte_m = 8'h01; end
      2'd1:    begin align_m = 3'b001; byte_m = 8'h03; end
      2'd2:    begin align_m = 3'b011; byte_m = 8'h0F; end
      default: begin align_m = 3'b111; byte_m = 8'hFF; end
    endcase
  end

  assign lane       = ea[LB-1:0];
  assign mem_access = memRead | memWrite;
  assign misalign   = mem_access & ((ea[2:0] & align_m) != 3'b000);
  // Gating with reset makes an asserted reset drop the request immediately.
  assign req        = mem_access & ~misalign & reset;
  assign we         = req & memWrite;
  assign stall      = req & ~bus.mem_ready;

  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = {ea[XLEN-1:LB], {LB{1'b0}}};
  assign bus.mem_wdata = b_q << {lane, 3'b000};
  assign bus.mem_wstrb = we ? (NB'(byte_m) << lane) : '0;

  assign rdata_sh = bus.mem_rdata >> {lane, 3'b000};
  always_comb begin
    load_ext = rdata_sh;
    case (ir_q[14:12])
      3'b000:  load_ext = XLEN'($signed(rdata_sh[7:0]));
      3'b001:  load_ext = XLEN'($signed(rdata_sh[15:0]));
      3'b010:  load_ext = XLEN'($signed(rdata_sh[31:0]));
      3'b100:  load_ext = XLEN'(rdata_sh[7:0]);
      3'b101:  load_ext = XLEN'(rdata_sh[15:0]);
      3'b110:  load_ext = XLEN'(rdata_sh[31:0]);
      default: load_ext = rdata_sh;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    old_pc_d  = old_pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    if (!stall) begin
      if (PCWrite) pc_d = result;
      if (IRWrite) begin
        old_pc_d = pc_q;
        if (req && bus.mem_ready) ir_d = rdata_sh[31:0];
      end
      if (memRead && !memWrite && !IRWrite && req && bus.mem_ready) mdr_d = load_ext;
      a_d       = rd1;
      b_d       = rd2;
      alu_out_d = alu_res;
    end
  end

  assign rf_we = regWrite & ~stall & (rd != 5'd0) & (int'(rd) < NREGS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      old_pc_q  <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      old_pc_q  <= old_pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      if (rf_we) rf_q[rd] <= result;
    end
  end
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Bench for mc_datapath_hs (XLEN=32, NREGS=16, RESET_PC=0x100): the bench plays the
// controller and the memory, and checks against an instruction-level reference model.
module tb_mc_datapath_hs;
  localparam int          XLEN  = 32;
  localparam int          NREGS = 16;
  localparam logic [31:0] RPC   = 32'h100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic PCWrite, IRWrite, regWrite, addrSrc, memRead, memWrite;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, immSrc;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic func7, zero, neg, stall, misalign;

  mc_datapath_hs_if #(.XLEN(XLEN)) bus ();

  mc_datapath_hs #(.XLEN(XLEN), .NREGS(NREGS), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .regWrite(regWrite), .addrSrc(addrSrc),
    .memRead(memRead), .memWrite(memWrite),
    .resultSrc(resultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .immSrc(immSrc),
    .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .neg(neg), .stall(stall), .misalign(misalign),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural registers plus the memory image.
  logic [31:0] m_pc, m_oldpc, m_mdr;
  logic [31:0] m_rf [32];
  logic [7:0]  mem_b [2048];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_rf(input logic [4:0] r);
    return (r == 5'd0 || int'(r) >= NREGS) ? 32'd0 : m_rf[r];
  endfunction

  task automatic wr_rf(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0 && int'(r) < NREGS) m_rf[r] = v;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_oldpc = '0; m_mdr = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a+i] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] load_ref(input int ea, input logic [2:0] f3);
    int v;
    if (f3[1:0] == 2'd2) return word_at(ea);
    if (f3[1:0] == 2'd0) v = int'(mem_b[ea]);
    else v = int'(mem_b[ea]) + 256 * int'(mem_b[ea+1]);
    if (!f3[2] && f3[1:0] == 2'd0 && v >= 128) v = v - 256;
    if (!f3[2] && f3[1:0] == 2'd1 && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
      default: return a << b[4:0];
    endcase
  endfunction

  task automatic idle();
    PCWrite = 0; IRWrite = 0; regWrite = 0; addrSrc = 0; memRead = 0; memWrite = 0;
    resultSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ALUControl = 0; immSrc = 0;
  endtask

  task automatic bus_xfer(input string tag, input int waits, input logic [31:0] rdata);
    for (int w = 0; w < waits; w++) begin
      bus.mem_ready = 1'b0;
      #1;
      check_val({tag, "_stall"}, 32'(stall), 32'd1);
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    check_val({tag, "_nostall"}, 32'(stall), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    idle();
    IRWrite = 1; memRead = 1; PCWrite = 1; ALUSrcB = 2; resultSrc = 2;
    #1;
    check_val("fetch_req", 32'(bus.mem_req), 32'd1);
    check_val("fetch_addr", bus.mem_addr, m_pc);
    bus_xfer("fetch", waits, word);
    idle();
    m_oldpc = m_pc;
    m_pc    = m_pc + 32'd4;
    #1;
    check_val("opcode", 32'(opcode), 32'(word[6:0]));
    check_val("func3", 32'(func3), 32'(word[14:12]));
    check_val("func7", 32'(func7), 32'(word[30]));
    @(negedge clk);
  endtask

  // Combinational look at PC/oldPC through the address path; no clock edge involved.
  task automatic peek_src(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    idle();
    addrSrc = 1; resultSrc = 2; ALUSrcA = sel; ALUSrcB = 3;
    #1;
    check_val(tag, bus.mem_addr, exp & ~32'h3);
    idle();
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input int ea,
                         input int fw, input int waits);
    logic [11:0] imm;
    int sz;
    bit mis;
    imm = 12'(ea);
    fetch({imm, 5'd0, f3, rd, 7'b0000011}, fw);
    sz  = 1 << f3[1:0];
    mis = (ea % sz) != 0;
    memRead = 1; addrSrc = 1; resultSrc = 3; immSrc = 0;
    #1;
    check_val("ld_misalign", 32'(misalign), 32'(mis));
    check_val("ld_req", 32'(bus.mem_req), 32'(!mis));
    check_val("ld_we", 32'(bus.mem_we), 32'd0);
    check_val("ld_strb", 32'(bus.mem_wstrb), 32'd0);
    check_val("ld_addr", bus.mem_addr, 32'(ea) & ~32'h3);
    if (!mis) begin
      bus_xfer("ld", waits, word_at(ea & ~3));
      m_mdr = load_ref(ea, f3);
    end else begin
      check_val("ld_mis_stall", 32'(stall), 32'd0);
      @(negedge clk);
    end
    idle();
    regWrite = 1; resultSrc = 1;
    @(negedge clk);
    idle();
    wr_rf(rd, m_mdr);
  endtask

  task automatic do_store(input string tag, input logic [4:0] rs2, input logic [2:0] f3,
                          input int ea, input int fw, input int waits);
    logic [11:0] imm;
    logic [31:0] bval;
    int sz, off;
    bit mis;
    imm = 12'(ea);
    fetch({imm[11:5], rs2, 5'd0, f3, imm[4:0], 7'b0100011}, fw);
    sz   = 1 << f3[1:0];
    mis  = (ea % sz) != 0;
    off  = ea % 4;
    bval = rd_rf(rs2);
    memWrite = 1; addrSrc = 1; resultSrc = 3; immSrc = 1;
    #1;
    check_val({tag, "_misalign"}, 32'(misalign), 32'(mis));
    check_val({tag, "_req"}, 32'(bus.mem_req), 32'(!mis));
    check_val({tag, "_we"}, 32'(bus.mem_we), 32'(!mis));
    check_val({tag, "_addr"}, bus.mem_addr, 32'(ea) & ~32'h3);
    if (!mis) begin
      check_val({tag, "_strb"}, 32'(bus.mem_wstrb), 32'(((1 << sz) - 1) << off));
      check_val({tag, "_wdata"}, bus.mem_wdata, bval << (8 * off));
      for (int i = 0; i < sz; i++) mem_b[ea+i] = bval[8*i +: 8];
      bus_xfer(tag, waits, 32'd0);
    end else begin
      check_val({tag, "_mis_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
    end
    idle();
  endtask

  task automatic observe(input string tag, input logic [4:0] r);
    do_store(tag, r, 3'b010, 32'h400, 0, 0);
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] op, input int fw);
    logic [31:0] res;
    fetch({1'b0, 1'($urandom_range(0, 1)), 5'd0, rs2, rs1, 3'($urandom_range(0, 7)), rd,
           7'b0110011}, fw);
    @(negedge clk);
    res = alu_ref(op, rd_rf(rs1), rd_rf(rs2));
    ALUSrcA = 2; ALUSrcB = 0; ALUControl = op; resultSrc = 2;
    #1;
    check_val("alu_zero", 32'(zero), 32'(res == 32'd0));
    check_val("alu_neg", 32'(neg), 32'(res[31]));
    @(negedge clk);
    idle();
    regWrite = 1; resultSrc = 0;
    @(negedge clk);
    idle();
    wr_rf(rd, res);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] f3;
    int ea, sz, kind;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    idle();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    for (int i = 0; i < 2048; i++) mem_b[i] = 8'($urandom);
    put_word(32'h300, 32'h11223344);
    mem_b[32'h310] = 8'h80;
    put_word(32'h320, 32'hBEEF1234);
    put_word(32'h330, 32'hFFFFFFFF);
    put_word(32'h334, 32'd1);
    put_word(32'h338, 32'd31);

    // Held in reset with a fetch requested: no bus cycle, PC at RESET_PC.
    repeat (2) @(negedge clk);
    IRWrite = 1; memRead = 1;
    #1;
    check_val("rst_req", 32'(bus.mem_req), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_opcode", 32'(opcode), 32'd0);
    check_val("rst_func3", 32'(func3), 32'd0);
    check_val("rst_func7", 32'(func7), 32'd0);
    check_val("rst_pc", bus.mem_addr, RPC);
    idle();
    @(negedge clk);
    reset = 1'b1;

    // First fetch with two wait states, then a word load into x5.
    do_load(5'd5, 3'b010, 32'h300, 2, 1);
    peek_src("oldpc", 2'd1, m_oldpc);
    peek_src("pc", 2'd0, m_pc);

    do_store("sb", 5'd5, 3'b000, 32'h203, 0, 1);
    do_load(5'd6, 3'b000, 32'h310, 0, 0);
    observe("obs_lb", 5'd6);
    do_load(5'd7, 3'b100, 32'h310, 1, 2);
    observe("obs_lbu", 5'd7);
    do_load(5'd8, 3'b101, 32'h322, 0, 0);
    observe("obs_lhu", 5'd8);
    do_load(5'd9, 3'b010, 32'h202, 0, 0);
    observe("obs_mis", 5'd9);

    do_load(5'd10, 3'b010, 32'h330, 0, 0);
    do_load(5'd11, 3'b010, 32'h334, 0, 0);
    do_load(5'd12, 3'b010, 32'h338, 0, 0);
    do_alu(5'd13, 5'd10, 5'd11, 3'd5, 0);
    do_alu(5'd14, 5'd10, 5'd11, 3'd6, 0);
    do_alu(5'd15, 5'd11, 5'd12, 3'd7, 0);
    observe("obs_slt", 5'd13);
    observe("obs_sltu", 5'd14);
    observe("obs_sll", 5'd15);
    do_load(5'd0, 3'b010, 32'h300, 0, 0);
    observe("obs_x0", 5'd0);
    do_load(5'd20, 3'b010, 32'h300, 0, 0);
    observe("obs_x20", 5'd20);

    for (int it = 0; it < 90; it++) begin
      kind = $urandom_range(0, 3);
      ea   = $urandom_range(32'h200, 32'h7F0);
      if (kind == 0) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        sz = 1 << f3[1:0];
        if ($urandom_range(0, 3) != 0) ea = ea - (ea % sz);
        do_load(5'($urandom_range(0, 31)), f3, ea, $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (kind == 1) begin
        f3 = 3'($urandom_range(0, 2));
        sz = 1 << f3[1:0];
        if ($urandom_range(0, 3) != 0) ea = ea - (ea % sz);
        do_store("st", 5'($urandom_range(0, 17)), f3, ea, $urandom_range(0, 2), $urandom_range(0, 3));
      end else if (kind == 2) begin
        do_alu(5'($urandom_range(1, 17)), 5'($urandom_range(0, 17)), 5'($urandom_range(0, 17)),
               3'($urandom_range(0, 7)), $urandom_range(0, 2));
      end else begin
        observe("obs_rand", 5'($urandom_range(0, 17)));
      end
    end

    // Reset asserted while a load is stalled.
    do_load(5'd5, 3'b010, 32'h300, 0, 0);
    fetch({12'h300, 5'd0, 3'b010, 5'd6, 7'b0000011}, 0);
    memRead = 1; addrSrc = 1; resultSrc = 3; immSrc = 0;
    bus.mem_ready = 1'b0;
    #1;
    check_val("pre_rst_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_req", 32'(bus.mem_req), 32'd0);
    check_val("arst_stall", 32'(stall), 32'd0);
    check_val("arst_opcode", 32'(opcode), 32'd0);
    check_val("arst_func3", 32'(func3), 32'd0);
    model_reset();
    idle();
    memRead = 1;
    #1;
    check_val("arst_pc", bus.mem_addr, RPC);
    idle();
    @(negedge clk);
    reset = 1'b1;
    observe("obs_after_rst", 5'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
